rr_arb8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- A rotating-priority 8-to-3 encoder picks the winner, and the grant is registered.
- A grant is held while the winner keeps requesting, up to a hold limit.
- Sits in front of any shared datapath resource; the 3-bit grant index drives the resource's input mux.

---
 rtl/rr_arb8_pkg.sv | 13 +
 rtl/rr_arb8_if.sv | 20 ++
 rtl/rr_arb8_penc8.sv | 32 +++
 rtl/rr_arb8.sv | 113 +++++++++++
 tb/tb_rr_arb8.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared constants and FSM encoding for the 8-way round-robin arbiter.
package rr_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // IDLE: no grant outstanding. GRANT: gnt/gnt_idx hold a live winner.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters and the arbiter.
//
// Handshake: req is level-sensitive. A requester keeps its bit high for as
// long as it wants the resource. The arbiter answers with a registered
// one-hot gnt (plus gnt_idx/gnt_vld) one edge after it decides, and it holds
// that answer until the winner drops req or the hold limit is reached. There
// is no separate ready or acknowledge: gnt itself is the permission to use
// the resource in that cycle.
interface rr_arb8_if;
  import rr_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;

  modport master (output req, input gnt, input gnt_idx, input gnt_vld);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_vld);

endinterface

// File: rtl/rr_arb8_penc8.sv
// Rotating-priority 8-to-3 encoder: finds the first set request at or after
// ptr, wrapping modulo 8. The search order is ptr, ptr+1, ..., ptr+7.
module rr_penc8
  import rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   enc;

  // Duplicating the vector turns the right-rotate by ptr into a plain slice.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_REQ];

  // Fixed-priority encode of the rotated vector, LSB wins.
  always_comb begin
    enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = IDX_W'(i);
    end
  end

  // Undo the rotation; 3-bit addition wraps modulo 8.
  assign idx = enc + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with a registered grant and a
// per-grant hold limit. A released grant hands over on the same edge, so the
// resource sees no idle cycle while anyone is waiting.
module rr_arb8
  import rr_pkg::*;
#(
  parameter int HOLD_MAX = 4
)(
  input  logic       clk,
  input  logic       rst,
  rr_arb8_if.slave   bus,
  output state_t     dbg_state
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             vld_q, vld_d;

  logic [IDX_W-1:0] arb_ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             cur_req;
  logic             at_limit;

  assign cur_req  = bus.req[idx_q];
  assign at_limit = (cnt_q == 4'(HOLD_MAX));

  // While granting, the encoder already searches from the post-release
  // pointer so a handover can be loaded on the same edge as the release.
  assign arb_ptr = (state_q == GRANT) ? idx_q + 3'd1 : ptr_q;

  rr_penc8 u_penc (
    .req (bus.req),
    .ptr (arb_ptr),
    .idx (win_idx),
    .any (win_any)
  );

  // Next-state and next-output decision.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = GRANT;
          idx_d   = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          vld_d   = 1'b1;
          cnt_d   = 4'd1;
        end
      end
      GRANT: begin
        if (cur_req && !at_limit) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          ptr_d = idx_q + 3'd1;
          if (win_any) begin
            idx_d = win_idx;
            gnt_d = N_REQ'(1) << win_idx;
            vld_d = 1'b1;
            cnt_d = 4'd1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            gnt_d   = '0;
            vld_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        gnt_d   = '0;
        vld_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: directed scenarios plus a randomized run, all compared
// against a queue-free behavioural model of round-robin arbitration.
module tb_rr_arb8;
  import rr_pkg::*;

  localparam int HOLD = 4;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  rr_arb8_if bus ();

  rr_arb8 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Clock and initial drive.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = none), pointer, cycles held.
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_edge(logic [7:0] r, logic rs);
    int w;
    if (rs) begin
      m_own = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_own < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin m_own = w; m_cnt = 1; end
    end else if (r[m_own] && m_cnt < HOLD) begin
      m_cnt++;
    end else begin
      m_ptr = (m_own + 1) % 8;
      w = pick(r, m_ptr);
      m_own = w;
      m_cnt = (w >= 0) ? 1 : 0;
    end
  endfunction

  function automatic logic [7:0] exp_gnt();
    logic [7:0] one;
    one = 8'd1;
    return (m_own < 0) ? 8'h00 : (one << m_own);
  endfunction

  function automatic logic [2:0] exp_idx();
    return (m_own < 0) ? 3'd0 : 3'(m_own);
  endfunction

  // Driver: set inputs on the falling edge, step one rising edge, then
  // advance the model and settle for sampling.
  task automatic drive(logic rs, logic [7:0] r);
    @(negedge clk);
    rst = rs;
    bus.req = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(bus.req, rst);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0 || bus.gnt_idx !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d gnt=%h vld=%b idx=%0d want gnt=00 vld=0 idx=0",
                 c, bus.gnt, bus.gnt_vld, bus.gnt_idx);
      end
    end
    drive(1'b0, 8'hFF);
    for (int c = 0; c < 36; c++) begin
      logic [2:0] want;
      logic [7:0] one;
      tick();
      want = 3'((c / HOLD) % 8);
      one  = 8'd1;
      checks++;
      if (bus.gnt_idx !== want || bus.gnt !== (one << want) || bus.gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL reset_rotation cyc=%0d idx=%0d gnt=%h vld=%b want idx=%0d gnt=%h",
                 c, bus.gnt_idx, bus.gnt, bus.gnt_vld, want, one << want);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b1, 8'h00);
    tick();
    drive(1'b0, 8'b0010_0000);
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (bus.gnt !== 8'b0010_0000 || bus.gnt_idx !== 3'd5 || bus.gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL single cyc=%0d gnt=%h idx=%0d vld=%b want gnt=20 idx=5 vld=1",
                 c, bus.gnt, bus.gnt_idx, bus.gnt_vld);
      end
    end
  endtask

  task automatic test_two();
    drive(1'b1, 8'h00);
    tick();
    drive(1'b0, 8'b1000_0001);
    for (int c = 0; c < 16; c++) begin
      logic [2:0] want;
      tick();
      want = ((c / HOLD) % 2 == 0) ? 3'd0 : 3'd7;
      checks++;
      if (bus.gnt_idx !== want || bus.gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL two_req cyc=%0d idx=%0d vld=%b want idx=%0d vld=1",
                 c, bus.gnt_idx, bus.gnt_vld, want);
      end
    end
  endtask

  task automatic test_early_and_wrap();
    drive(1'b1, 8'h00);
    tick();
    drive(1'b0, 8'b0100_0100);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.gnt_idx !== 3'd2 || bus.gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL early_first cyc=%0d idx=%0d vld=%b want idx=2 vld=1",
                 c, bus.gnt_idx, bus.gnt_vld);
      end
    end
    drive(1'b0, 8'b0100_0000);
    tick();
    checks++;
    if (bus.gnt_idx !== 3'd6 || bus.gnt !== 8'h40) begin
      errors++;
      $display("FAIL early_handover idx=%0d gnt=%h want idx=6 gnt=40", bus.gnt_idx, bus.gnt);
    end
    drive(1'b0, 8'h00);
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL early_drop gnt=%h vld=%b state=%0d want gnt=00 vld=0 state=0",
               bus.gnt, bus.gnt_vld, dbg_state);
    end
    // Pointer now sits at 7, so requester 0 must beat requester 6.
    drive(1'b0, 8'b0100_0001);
    for (int c = 0; c < 5; c++) begin
      logic [2:0] want;
      tick();
      want = (c < HOLD) ? 3'd0 : 3'd6;
      checks++;
      if (bus.gnt_idx !== want || bus.gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL wrap cyc=%0d idx=%0d vld=%b want idx=%0d", c, bus.gnt_idx, bus.gnt_vld, want);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 8'h00);
    tick();
    drive(1'b0, 8'h01);
    tick();
    drive(1'b0, 8'h00);
    tick();
    drive(1'b0, 8'h08);
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (bus.gnt_idx !== 3'd3 || bus.gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre idx=%0d vld=%b want idx=3 vld=1", bus.gnt_idx, bus.gnt_vld);
    end
    drive(1'b1, 8'h08);
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear gnt=%h vld=%b want gnt=00 vld=0", bus.gnt, bus.gnt_vld);
    end
    drive(1'b0, 8'b0000_1001);
    tick();
    checks++;
    if (bus.gnt_idx !== 3'd0 || bus.gnt !== 8'h01) begin
      errors++;
      $display("FAIL midrst_regrant idx=%0d gnt=%h want idx=0 gnt=01", bus.gnt_idx, bus.gnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       rs;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'($urandom);
        1:       r = 8'($urandom) & 8'($urandom);
        2:       r = (c % 7 == 0) ? 8'h00 : bus.req;
        default: r = bus.req ^ (8'd1 << $urandom_range(0, 7));
      endcase
      rs = ($urandom_range(0, 99) == 0);
      drive(rs, r);
      tick();
      checks++;
      if (bus.gnt !== exp_gnt() || bus.gnt_idx !== exp_idx() || bus.gnt_vld !== (m_own >= 0)) begin
        errors++;
        $display("FAIL random_model cyc=%0d req=%h gnt=%h idx=%0d vld=%b want gnt=%h idx=%0d vld=%b",
                 c, r, bus.gnt, bus.gnt_idx, bus.gnt_vld, exp_gnt(), exp_idx(), m_own >= 0);
      end
      checks++;
      if (bus.gnt_vld && !r[bus.gnt_idx]) begin
        errors++;
        $display("FAIL random_unrequested cyc=%0d req=%h idx=%0d want a requesting index",
                 c, r, bus.gnt_idx);
      end
      checks++;
      if (($countones(bus.gnt) > 1) || (bus.gnt_vld !== (|bus.gnt))) begin
        errors++;
        $display("FAIL random_onehot cyc=%0d gnt=%h vld=%b want one-hot gnt with vld=|gnt",
                 c, bus.gnt, bus.gnt_vld);
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    rst = 1'b1;
    bus.req = 8'h00;
    test_reset();
    test_single();
    test_two();
    test_early_and_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
